// File: rtl/fb_ctrl_pkg.sv
// Shared definitions for the camera frame-buffer write controller.
//   fb_state_t        : capture-session FSM encoding (IDLE / ARMED / CAPTURE)
//   *_DEF             : default frame-buffer geometry and downsample shift
//   fb_addr_width()   : address width needed to cover a width x height buffer
package fb_ctrl_pkg;

    localparam int FB_WIDTH_DEF  = 320;
    localparam int FB_HEIGHT_DEF = 180;
    localparam int DS_SHIFT_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } fb_state_t;

    function automatic int fb_addr_width(input int width, input int height);
        return $clog2(width * height);
    endfunction

endpackage

// File: rtl/fb_write_ctrl_if.sv
// Pixel-in / BRAM-port-A-out bundle for fb_write_ctrl.
//   pixel_valid_in, pixel_hcount_in, pixel_vcount_in, pixel_data_in : reconstructed pixel stream
//   addra_out, wea_out, dina_out                                    : frame-buffer port A
// Modports:
//   master : pixel source side (drives the stream, observes the BRAM writes)
//   slave  : the write controller
// Handshake: the pixel stream is valid-only. pixel_valid_in qualifies the
// coordinates and data in the same cycle; there is no ready, the controller
// takes every valid beat. wea_out qualifies addra_out/dina_out the same way.
interface fb_write_ctrl_if
    import fb_ctrl_pkg::*;
#(
    parameter int ADDR_W = fb_addr_width(FB_WIDTH_DEF, FB_HEIGHT_DEF)
);
    logic              pixel_valid_in;
    logic [10:0]       pixel_hcount_in;
    logic [9:0]        pixel_vcount_in;
    logic [15:0]       pixel_data_in;
    logic [ADDR_W-1:0] addra_out;
    logic              wea_out;
    logic [15:0]       dina_out;

    modport master (
        output pixel_valid_in, pixel_hcount_in, pixel_vcount_in, pixel_data_in,
        input  addra_out, wea_out, dina_out
    );

    modport slave (
        input  pixel_valid_in, pixel_hcount_in, pixel_vcount_in, pixel_data_in,
        output addra_out, wea_out, dina_out
    );
endinterface

// File: rtl/fb_addr_gen.sv
// Combinational pixel decode for the frame-buffer writer.
//   pixel_valid, hcount, vcount : source pixel strobe and coordinates
//   kept        : pixel survives 2^DS_SHIFT decimation and lies inside the buffer
//   frame_start : kept pixel at source (0,0)
//   last_pixel  : kept pixel at buffer (FB_WIDTH-1, FB_HEIGHT-1)
//   addr        : y*FB_WIDTH + x, computed at 32 bits then truncated to ADDR_W
module fb_addr_gen
    import fb_ctrl_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF,
    parameter int DS_SHIFT  = DS_SHIFT_DEF,
    parameter int ADDR_W    = fb_addr_width(FB_WIDTH_DEF, FB_HEIGHT_DEF)
) (
    input  logic              pixel_valid,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    output logic              kept,
    output logic              frame_start,
    output logic              last_pixel,
    output logic [ADDR_W-1:0] addr
);
    logic [10:0]         x;
    logic [9:0]          y;
    logic [DS_SHIFT-1:0] h_low;
    logic [DS_SHIFT-1:0] v_low;

    always_comb begin
        x     = hcount >> DS_SHIFT;
        y     = vcount >> DS_SHIFT;
        h_low = hcount[DS_SHIFT-1:0];
        v_low = vcount[DS_SHIFT-1:0];

        kept = pixel_valid && (h_low == '0) && (v_low == '0)
               && (32'(x) < 32'(FB_WIDTH)) && (32'(y) < 32'(FB_HEIGHT));
        frame_start = kept && (hcount == '0) && (vcount == '0);
        last_pixel  = kept && (32'(x) == 32'(FB_WIDTH - 1))
                           && (32'(y) == 32'(FB_HEIGHT - 1));

        // Full-width multiply-add first so the truncation never clips a partial product.
        addr = ADDR_W'(32'(y) * 32'(FB_WIDTH) + 32'(x));
    end
endmodule

// File: rtl/fb_write_ctrl.sv
// Camera frame-buffer write controller (clk_camera domain).
// Decimates the reconstructed pixel stream and writes it into BRAM port A,
// running capture sessions started and stopped by one-cycle commands.
//   clk_camera, sys_rst_camera : clock, asynchronous active-high reset
//   pix_bram (slave)           : pixel stream in, port-A address/enable/data out
//   mode_in                    : 0 continuous, 1 single frame (latched on accepted start)
//   start_in, stop_in          : one-cycle commands; stop wins when both are high
//   busy_out                   : registered copy of (state != IDLE), trails the state by one cycle
//   frame_done_out             : pulse coincident with the last write of a frame
//   frame_count_out            : completed frames, wraps at 16 bits
//   state_out                  : current FSM state for observation
module fb_write_ctrl
    import fb_ctrl_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF,
    parameter int DS_SHIFT  = DS_SHIFT_DEF
) (
    input  logic               clk_camera,
    input  logic               sys_rst_camera,
    fb_write_ctrl_if.slave     pix_bram,
    input  logic               mode_in,
    input  logic               start_in,
    input  logic               stop_in,
    output logic               busy_out,
    output logic               frame_done_out,
    output logic [15:0]        frame_count_out,
    output fb_state_t          state_out
);
    localparam int FB_SIZE = fb_addr_width(FB_WIDTH, FB_HEIGHT);

    logic               kept;
    logic               frame_start;
    logic               last_pixel;
    logic [FB_SIZE-1:0] addr;

    fb_state_t          state_q, state_d;
    logic               mode_q, mode_d;
    logic               stop_pend_q, stop_pend_d;
    logic               write_en;
    logic               done_d;

    logic               wea_q;
    logic [FB_SIZE-1:0] addra_q;
    logic [15:0]        dina_q;
    logic               done_q;
    logic [15:0]        frame_count_q;
    logic               busy_q;

    fb_addr_gen #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .DS_SHIFT  (DS_SHIFT),
        .ADDR_W    (FB_SIZE)
    ) u_addr_gen (
        .pixel_valid (pix_bram.pixel_valid_in),
        .hcount      (pix_bram.pixel_hcount_in),
        .vcount      (pix_bram.pixel_vcount_in),
        .kept        (kept),
        .frame_start (frame_start),
        .last_pixel  (last_pixel),
        .addr        (addr)
    );

    always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
        if (sys_rst_camera) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        stop_pend_d = stop_pend_q;
        write_en    = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_in && !stop_in) begin
                    state_d = ARMED;
                    mode_d  = mode_in;
                end
            end
            ARMED: begin
                if (stop_in) begin
                    state_d = IDLE;
                end else if (frame_start) begin
                    state_d  = CAPTURE;
                    write_en = 1'b1;
                end
            end
            CAPTURE: begin
                // A frame start seen here is a truncated frame: the address
                // already restarts at 0 from the coordinates, so just write it.
                write_en = kept;
                if (stop_in) begin
                    stop_pend_d = 1'b1;
                end
                if (last_pixel) begin
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                    // stop_in on the last pixel itself still ends the session.
                    state_d     = (mode_q || stop_pend_q || stop_in) ? IDLE : ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
        if (sys_rst_camera) begin
            wea_q         <= 1'b0;
            addra_q       <= '0;
            dina_q        <= '0;
            done_q        <= 1'b0;
            frame_count_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            wea_q  <= write_en;
            done_q <= done_d;
            busy_q <= (state_q != IDLE);
            if (write_en) begin
                addra_q <= addr;
                dina_q  <= pix_bram.pixel_data_in;
            end
            if (done_d) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign pix_bram.wea_out   = wea_q;
    assign pix_bram.addra_out = addra_q;
    assign pix_bram.dina_out  = dina_q;
    assign frame_done_out     = done_q;
    assign frame_count_out    = frame_count_q;
    assign busy_out           = busy_q;
    assign state_out          = state_q;
endmodule

// File: tb/tb_fb_write_ctrl.sv
module tb_fb_write_ctrl;
    import fb_ctrl_pkg::*;

    // Small instance for whole-frame sessions: 8x6 buffer, 32x24 active source, 40x28 raster.
    localparam int SW   = 8;
    localparam int SH   = 6;
    localparam int S_AW = 6;
    localparam int F_AW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    fb_write_ctrl_if #(.ADDR_W(S_AW)) s_bus ();
    fb_write_ctrl_if #(.ADDR_W(F_AW)) f_bus ();

    logic        s_mode = 1'b0, s_start = 1'b0, s_stop = 1'b0;
    logic        s_busy, s_done;
    logic [15:0] s_count;
    fb_state_t   s_state;

    logic        f_mode = 1'b0, f_start = 1'b0, f_stop = 1'b0;
    logic        f_busy, f_done;
    logic [15:0] f_count;
    fb_state_t   f_state;

    fb_write_ctrl #(.FB_WIDTH(SW), .FB_HEIGHT(SH), .DS_SHIFT(2)) dut (
        .clk_camera      (clk),
        .sys_rst_camera  (rst),
        .pix_bram        (s_bus),
        .mode_in         (s_mode),
        .start_in        (s_start),
        .stop_in         (s_stop),
        .busy_out        (s_busy),
        .frame_done_out  (s_done),
        .frame_count_out (s_count),
        .state_out       (s_state)
    );

    fb_write_ctrl dut_full (
        .clk_camera      (clk),
        .sys_rst_camera  (rst),
        .pix_bram        (f_bus),
        .mode_in         (f_mode),
        .start_in        (f_start),
        .stop_in         (f_stop),
        .busy_out        (f_busy),
        .frame_done_out  (f_done),
        .frame_count_out (f_count),
        .state_out       (f_state)
    );

    // ---------------- write monitor (small DUT) ----------------
    logic [S_AW-1:0] wr_q[$];
    logic [15:0]     wd_q[$];
    int              done_cnt = 0;
    int              done_cyc = -1;
    int              busy_fall_cyc = -1;
    logic [S_AW-1:0] done_addr = '0;
    logic            done_wea = 1'b0;
    logic            busy_prev = 1'b0;

    always @(negedge clk) begin
        if (s_bus.wea_out === 1'b1) begin
            wr_q.push_back(s_bus.addra_out);
            wd_q.push_back(s_bus.dina_out);
        end
        if (s_done === 1'b1) begin
            done_cnt  = done_cnt + 1;
            done_addr = s_bus.addra_out;
            done_wea  = s_bus.wea_out;
            done_cyc  = cyc;
        end
        if (busy_prev && !s_busy) busy_fall_cyc = cyc;
        busy_prev = s_busy;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_q.delete();
        wd_q.delete();
        done_cnt      = 0;
        done_cyc      = -1;
        busy_fall_cyc = -1;
    endtask

    task automatic pulse_start(input logic mode);
        s_mode  = mode;
        s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        s_mode  = 1'b0;
    endtask

    task automatic pulse_stop();
        s_stop = 1'b1;
        tick(1);
        s_stop = 1'b0;
    endtask

    task automatic raster(input int rows, input int stop_row);
        for (int v = 0; v < rows; v++) begin
            for (int h = 0; h < 40; h++) begin
                s_bus.pixel_valid_in  = 1'b1;
                s_bus.pixel_hcount_in = 11'(h);
                s_bus.pixel_vcount_in = 10'(v);
                s_bus.pixel_data_in   = {8'(v), 8'(h)};
                s_stop = (v == stop_row) && (h == 0);
                tick(1);
            end
        end
        s_bus.pixel_valid_in = 1'b0;
        s_stop = 1'b0;
        tick(3);
    endtask

    task automatic fpix(input logic valid, input int h, input int v, input logic [15:0] d);
        f_bus.pixel_valid_in  = valid;
        f_bus.pixel_hcount_in = 11'(h);
        f_bus.pixel_vcount_in = 10'(v);
        f_bus.pixel_data_in   = d;
        tick(1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        s_bus.pixel_valid_in = 1'b0; s_bus.pixel_hcount_in = '0;
        s_bus.pixel_vcount_in = '0;  s_bus.pixel_data_in = '0;
        f_bus.pixel_valid_in = 1'b0; f_bus.pixel_hcount_in = '0;
        f_bus.pixel_vcount_in = '0;  f_bus.pixel_data_in = '0;

        // Reset state
        tick(2);
        chk("rst_wea",   32'(s_bus.wea_out), 0);
        chk("rst_addra", 32'(s_bus.addra_out), 0);
        chk("rst_dina",  32'(s_bus.dina_out), 0);
        chk("rst_busy",  32'(s_busy), 0);
        chk("rst_done",  32'(s_done), 0);
        chk("rst_count", 32'(s_count), 0);
        chk("rst_state", 32'(s_state), 32'(IDLE));
        rst = 1'b0;
        tick(1);

        // Full-size geometry: address mapping and last pixel
        f_mode = 1'b0; f_start = 1'b1; tick(1); f_start = 1'b0;
        chk("full_armed", 32'(f_state), 32'(ARMED));
        fpix(1'b1, 0, 0, 16'h1111);
        chk("full_p0_wea",  32'(f_bus.wea_out), 1);
        chk("full_p0_addr", 32'(f_bus.addra_out), 0);
        fpix(1'b1, 8, 4, 16'hABCD);
        chk("full_322_wea",  32'(f_bus.wea_out), 1);
        chk("full_322_addr", 32'(f_bus.addra_out), 322);
        chk("full_322_data", 32'(f_bus.dina_out), 32'h0000ABCD);
        fpix(1'b1, 9, 4, 16'h2222);
        chk("full_odd_h_wea",  32'(f_bus.wea_out), 0);
        chk("full_odd_h_hold", 32'(f_bus.addra_out), 322);
        fpix(1'b1, 1280, 716, 16'h3333);
        chk("full_oob_wea", 32'(f_bus.wea_out), 0);
        fpix(1'b1, 1276, 716, 16'h5A5A);
        chk("full_last_wea",   32'(f_bus.wea_out), 1);
        chk("full_last_addr",  32'(f_bus.addra_out), 57599);
        chk("full_last_done",  32'(f_done), 1);
        chk("full_last_count", 32'(f_count), 1);
        fpix(1'b0, 0, 0, 16'h0000);
        chk("full_done_pulse", 32'(f_done), 0);
        chk("full_rearmed",    32'(f_state), 32'(ARMED));

        // 1: continuous, two frames
        pulse_start(1'b0);
        chk("t1_armed", 32'(s_state), 32'(ARMED));
        clear_mon();
        raster(28, -1);
        raster(28, -1);
        chk("t1_writes",    32'(wr_q.size()), 96);
        chk("t1_done_cnt",  32'(done_cnt), 2);
        chk("t1_count",     32'(s_count), 2);
        chk("t1_addr0",     32'(wr_q[0]), 0);
        chk("t1_addr_8_4",  32'(wr_q[10]), 10);
        chk("t1_data_8_4",  32'(wd_q[10]), 32'h0408);
        chk("t1_addr47",    32'(wr_q[47]), 47);
        chk("t1_f2_addr0",  32'(wr_q[48]), 0);
        chk("t1_done_addr", 32'(done_addr), 47);
        chk("t1_done_wea",  32'(done_wea), 1);
        chk("t1_state",     32'(s_state), 32'(ARMED));
        chk("t1_busy",      32'(s_busy), 1);

        // 4a: stop in ARMED
        pulse_stop();
        chk("t4_stop_idle", 32'(s_state), 32'(IDLE));
        tick(1);
        chk("t4_stop_busy", 32'(s_busy), 0);

        // 2: single frame, three frames streamed
        pulse_start(1'b1);
        clear_mon();
        raster(28, -1);
        raster(28, -1);
        raster(28, -1);
        chk("t2_writes",    32'(wr_q.size()), 48);
        chk("t2_done_cnt",  32'(done_cnt), 1);
        chk("t2_count",     32'(s_count), 3);
        chk("t2_busy_fall", 32'(busy_fall_cyc - done_cyc), 1);
        chk("t2_state",     32'(s_state), 32'(IDLE));

        // 3: stop mid-CAPTURE, continuous
        pulse_start(1'b0);
        clear_mon();
        raster(28, 12);
        raster(28, -1);
        chk("t3_writes",   32'(wr_q.size()), 48);
        chk("t3_done_cnt", 32'(done_cnt), 1);
        chk("t3_count",    32'(s_count), 4);
        chk("t3_state",    32'(s_state), 32'(IDLE));

        // 4b: start and stop together from IDLE
        s_start = 1'b1; s_stop = 1'b1;
        tick(1);
        s_start = 1'b0; s_stop = 1'b0;
        chk("t4_both_state", 32'(s_state), 32'(IDLE));
        tick(1);
        chk("t4_both_busy", 32'(s_busy), 0);

        // start while busy does not re-latch mode
        pulse_start(1'b0);
        pulse_start(1'b1);
        clear_mon();
        raster(28, -1);
        raster(28, -1);
        chk("t4_busy_start_writes", 32'(wr_q.size()), 96);
        chk("t4_busy_start_done",   32'(done_cnt), 2);
        chk("t4_busy_start_count",  32'(s_count), 6);
        chk("t4_busy_start_state",  32'(s_state), 32'(ARMED));
        pulse_stop();

        // 5: truncated frame, single mode
        pulse_start(1'b1);
        clear_mon();
        raster(16, -1);
        chk("t5_trunc_writes", 32'(wr_q.size()), 32);
        chk("t5_trunc_done",   32'(done_cnt), 0);
        chk("t5_trunc_count",  32'(s_count), 6);
        raster(28, -1);
        chk("t5_writes",    32'(wr_q.size()), 80);
        chk("t5_addr31",    32'(wr_q[31]), 31);
        chk("t5_restart",   32'(wr_q[32]), 0);
        chk("t5_done_cnt",  32'(done_cnt), 1);
        chk("t5_done_addr", 32'(done_addr), 47);
        chk("t5_count",     32'(s_count), 7);
        chk("t5_state",     32'(s_state), 32'(IDLE));

        // 6: async reset mid-CAPTURE
        pulse_start(1'b0);
        raster(12, -1);
        s_bus.pixel_valid_in  = 1'b1;
        s_bus.pixel_hcount_in = 11'd4;
        s_bus.pixel_vcount_in = 10'd12;
        s_bus.pixel_data_in   = 16'hBEEF;
        tick(1);
        s_bus.pixel_valid_in  = 1'b0;
        chk("t6_pre_wea",  32'(s_bus.wea_out), 1);
        chk("t6_pre_addr", 32'(s_bus.addra_out), 25);
        #3 rst = 1'b1;
        #2;
        chk("t6_rst_wea",   32'(s_bus.wea_out), 0);
        chk("t6_rst_addr",  32'(s_bus.addra_out), 0);
        chk("t6_rst_dina",  32'(s_bus.dina_out), 0);
        chk("t6_rst_busy",  32'(s_busy), 0);
        chk("t6_rst_done",  32'(s_done), 0);
        chk("t6_rst_count", 32'(s_count), 0);
        chk("t6_rst_state", 32'(s_state), 32'(IDLE));
        #2 rst = 1'b0;
        tick(1);
        clear_mon();
        raster(28, -1);
        chk("t6_idle_writes", 32'(wr_q.size()), 0);
        chk("t6_idle_done",   32'(done_cnt), 0);

        // frame counter wrap
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        pulse_start(1'b0);
        clear_mon();
        raster(28, -1);
        chk("t6_wrap_writes", 32'(wr_q.size()), 48);
        chk("t6_wrap_done",   32'(done_cnt), 1);
        chk("t6_wrap_count",  32'(s_count), 0);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
